// File: rtl/dsc_pkg.sv
// dsc_pkg: shared types and default sizing for the dsc_mul scheduler.
// Holds the scheduler state encoding and a modular-increment helper.
package dsc_pkg;

    localparam int DSC_NUM_REQ  = 4;
    localparam int DSC_NUM_BITS = 6;
    localparam int DSC_TIMEOUT  = 8192;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } dsc_state_t;

    // Next index after k in a ring of n slots.
    function automatic int dsc_wrap_inc(input int k, input int n);
        return (k + 1 >= n) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/dsc_rr_arb.sv
// dsc_rr_arb: combinational round-robin grant.
// Picks the first raised request at or after the pointer, wrapping around.
module dsc_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic               o_vld,
    output logic [ID_W-1:0]    o_id
);

    // Scan offsets from far to near so the nearest requester wins.
    always_comb begin
        int w_j;
        w_j   = 0;
        o_vld = 1'b0;
        o_id  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_j = int'(i_ptr) + i;
            if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
            if (i_req[w_j]) begin
                o_vld = 1'b1;
                o_id  = ID_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/dsc_mul_sched.sv
// dsc_mul_sched: shares one dsc_mul among NUM_REQ requesters.
// Grants round-robin, sequences LOAD/RUN/DONE and reports each result.
module dsc_mul_sched
    import dsc_pkg::*;
#(
    parameter  int NUM_REQ  = DSC_NUM_REQ,
    parameter  int NUM_BITS = DSC_NUM_BITS,
    parameter  int TIMEOUT  = DSC_TIMEOUT,
    localparam int ID_W     = $clog2(NUM_REQ),
    localparam int CYC_W    = $clog2(TIMEOUT + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*NUM_BITS-1:0]  req_a,
    input  logic [NUM_REQ*NUM_BITS-1:0]  req_b,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         res_valid,
    output logic [ID_W-1:0]              res_id,
    output logic [2*NUM_BITS-1:0]        res_z,
    output logic [CYC_W-1:0]             res_cycles,
    output logic                         res_err,
    output logic                         busy,
    output logic                         mul_rst,
    output logic                         mul_en,
    output logic [NUM_BITS-1:0]          mul_a,
    output logic [NUM_BITS-1:0]          mul_b,
    input  logic [2*NUM_BITS-1:0]        mul_z,
    input  logic                         mul_ov
);

    dsc_state_t              r_state;
    dsc_state_t              w_state_nxt;
    logic [ID_W-1:0]         r_ptr;
    logic [ID_W-1:0]         r_id;
    logic [ID_W-1:0]         w_gnt_id;
    logic [ID_W-1:0]         w_ptr_nxt;
    logic                    w_gnt_vld;
    logic [NUM_BITS-1:0]     r_a;
    logic [NUM_BITS-1:0]     r_b;
    logic [NUM_BITS-1:0]     w_sel_a;
    logic [NUM_BITS-1:0]     w_sel_b;
    logic [CYC_W-1:0]        r_cnt;
    logic [CYC_W-1:0]        w_cnt_nxt;
    logic                    w_zero_op;
    logic                    w_timeout;
    logic [2*NUM_BITS-1:0]   r_res_z;
    logic [CYC_W-1:0]        r_res_cycles;
    logic                    r_res_err;

    dsc_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_vld   (w_gnt_vld),
        .o_id    (w_gnt_id)
    );

    assign w_sel_a   = req_a[w_gnt_id*NUM_BITS +: NUM_BITS];
    assign w_sel_b   = req_b[w_gnt_id*NUM_BITS +: NUM_BITS];
    assign w_ptr_nxt = ID_W'(dsc_wrap_inc(int'(w_gnt_id), NUM_REQ));
    assign w_cnt_nxt = r_cnt + CYC_W'(1);
    assign w_timeout = (w_cnt_nxt == CYC_W'(TIMEOUT));
    assign w_zero_op = (r_a == '0) || (r_b == '0);

    assign res_id     = r_id;
    assign res_z      = r_res_z;
    assign res_cycles = r_res_cycles;
    assign res_err    = r_res_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state: zero operand skips RUN; overflow or timeout ends RUN.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_gnt_vld) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = w_zero_op ? S_DONE : S_RUN;
            S_RUN:   if (mul_ov || w_timeout) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs; multiplier held in reset outside RUN.
    always_comb begin
        busy      = (r_state != S_IDLE);
        mul_rst   = (r_state != S_RUN);
        mul_en    = (r_state == S_RUN);
        res_valid = (r_state == S_DONE);
        mul_a     = busy ? r_a : '0;
        mul_b     = busy ? r_b : '0;
        ack       = '0;
        if (r_state == S_DONE) ack[r_id] = 1'b1;
    end

    // Grant latch, RUN cycle counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            r_id         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_cnt        <= '0;
            r_res_z      <= '0;
            r_res_cycles <= '0;
            r_res_err    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_id  <= w_gnt_id;
                        r_a   <= w_sel_a;
                        r_b   <= w_sel_b;
                        r_ptr <= w_ptr_nxt;
                    end
                end
                S_LOAD: begin
                    r_cnt <= '0;
                    if (w_zero_op) begin
                        r_res_z      <= '0;
                        r_res_cycles <= '0;
                        r_res_err    <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_cnt <= w_cnt_nxt;
                    if (mul_ov) begin
                        r_res_z      <= mul_z;
                        r_res_cycles <= w_cnt_nxt;
                        r_res_err    <= 1'b0;
                    end else if (w_timeout) begin
                        r_res_z      <= '0;
                        r_res_cycles <= CYC_W'(TIMEOUT);
                        r_res_err    <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsc_mul_sched.sv
// tb_dsc_mul_sched: scoreboard bench for the dsc_mul scheduler.
// A behavioural dsc_mul stands in for the real multiplier.
module tb_dsc_mul_sched;

    localparam int NR    = 4;
    localparam int NB    = 6;
    localparam int TO    = 16;
    localparam int ID_W  = 2;
    localparam int CYC_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*NB-1:0]  req_a;
    logic [NR*NB-1:0]  req_b;
    logic [NR-1:0]     ack;
    logic              res_valid;
    logic [ID_W-1:0]   res_id;
    logic [2*NB-1:0]   res_z;
    logic [CYC_W-1:0]  res_cycles;
    logic              res_err;
    logic              busy;
    logic              mul_rst;
    logic              mul_en;
    logic [NB-1:0]     mul_a;
    logic [NB-1:0]     mul_b;
    logic [2*NB-1:0]   mul_z;
    logic              mul_ov;

    always #5 clk = ~clk;

    dsc_mul_sched #(
        .NUM_REQ    (NR),
        .NUM_BITS   (NB),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_a      (req_a),
        .req_b      (req_b),
        .ack        (ack),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_z      (res_z),
        .res_cycles (res_cycles),
        .res_err    (res_err),
        .busy       (busy),
        .mul_rst    (mul_rst),
        .mul_en     (mul_en),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_z      (mul_z),
        .mul_ov     (mul_ov)
    );

    // Multiplier latency in enabled cycles depends on the operands.
    function automatic int lat_of(input logic [NB-1:0] a, input logic [NB-1:0] b);
        return 1 + (int'(a ^ b) % 12);
    endfunction

    int  m_cnt;
    bit  kill_ov = 1'b0;

    always @(posedge clk) begin
        if (mul_rst)     m_cnt <= 0;
        else if (mul_en) m_cnt <= m_cnt + 1;
    end

    assign mul_z  = mul_a * mul_b;
    assign mul_ov = mul_en && !kill_ov && (m_cnt == lat_of(mul_a, mul_b) - 1);

    typedef struct {
        int id;
        int z;
        int cyc;
        int err;
    } exp_t;

    exp_t          q[$];
    exp_t          m_e;
    int            total = 0;
    int            bad   = 0;
    int            n_res = 0;
    int            n_iss = 0;
    int            m_ptr = 0;
    bit            at_done = 1'b0;
    logic [NB-1:0] a_v [NR];
    logic [NB-1:0] b_v [NR];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Monitor: every result strobe is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("rst_en_onehot", 32'(mul_rst ^ mul_en), 32'd1);
            if (res_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got id=%0d z=%0d want none",
                             res_id, res_z);
                end else begin
                    m_e = q.pop_front();
                    chk("res_id", 32'(res_id), m_e.id);
                    chk("res_z", 32'(res_z), m_e.z);
                    chk("res_cycles", 32'(res_cycles), m_e.cyc);
                    chk("res_err", 32'(res_err), m_e.err);
                    chk("ack", 32'(ack), 32'd1 << m_e.id);
                    n_res++;
                end
            end else begin
                chk("stray_ack", 32'(ack), 32'd0);
            end
        end
    end

    task automatic idle(input int n);
        req = '0;
        repeat (n) @(negedge clk);
        at_done = 1'b0;
    endtask

    // Predict the grant and result, drive the request, wait for completion.
    task automatic do_op(input logic [NR-1:0] pat, input bit to, input bit drop,
                         output int gid);
        int            id;
        int            run;
        int            n;
        int            en;
        exp_t          x;
        logic [NB-1:0] a;
        logic [NB-1:0] b;
        id = -1;
        for (int i = 0; i < NR; i++) begin
            int j;
            j = (m_ptr + i) % NR;
            if (id < 0 && pat[j]) id = j;
        end
        m_ptr = (id + 1) % NR;
        a = a_v[id];
        b = b_v[id];
        if (a == 0 || b == 0) begin
            run = 0;
            x = '{id, 0, 0, 0};
        end else if (to) begin
            run = TO;
            x = '{id, 0, TO, 1};
        end else begin
            run = lat_of(a, b);
            x = '{id, int'(a) * int'(b), run, 0};
        end
        q.push_back(x);
        n_iss++;
        for (int i = 0; i < NR; i++) begin
            req_a[i*NB +: NB] = a_v[i];
            req_b[i*NB +: NB] = b_v[i];
        end
        kill_ov = to;
        req = pat;
        n = 0;
        en = 0;
        do begin
            @(negedge clk);
            n++;
            if (mul_en) en++;
            if (drop && n == 1) req = ~pat;
            if (drop && n == 2) req = '0;
        end while (!res_valid && n < 200);
        chk("latency", n, (at_done ? 3 : 2) + run);
        chk("en_cycles", en, run);
        at_done = 1'b1;
        gid = id;
    endtask

    int ord [5] = '{0, 1, 2, 3, 0};
    int gid;

    initial begin
        rst   = 1'b1;
        req   = '0;
        req_a = '0;
        req_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mul_rst", 32'(mul_rst), 1);
        chk("rst_mul_en", 32'(mul_en), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_z", 32'(res_z), 0);
        chk("rst_mul_a", 32'(mul_a), 0);
        rst = 1'b0;
        @(negedge clk);
        at_done = 1'b0;

        for (int i = 0; i < NR; i++) begin
            a_v[i] = NB'(i + 3);
            b_v[i] = NB'(2 * i + 5);
        end
        for (int k = 0; k < 5; k++) begin
            do_op(4'b1111, 1'b0, 1'b0, gid);
            chk("rr_order", gid, ord[k]);
        end
        idle(2);

        a_v[0] = 6'd15;
        b_v[0] = 6'd15;
        do_op(4'b0001, 1'b0, 1'b0, gid);
        chk("sq15_id", gid, 0);
        idle(1);

        a_v[2] = 6'd0;
        b_v[2] = 6'd37;
        do_op(4'b0100, 1'b0, 1'b0, gid);
        idle(1);

        a_v[1] = 6'd5;
        b_v[1] = 6'd9;
        do_op(4'b0010, 1'b1, 1'b0, gid);
        kill_ov = 1'b0;
        idle(1);

        a_v[0] = 6'd21;
        b_v[0] = 6'd2;
        do_op(4'b0001, 1'b0, 1'b1, gid);
        idle(6);
        chk("drop_one_ack", n_res, n_iss);

        a_v[1] = 6'd7;
        b_v[1] = 6'd9;
        for (int i = 0; i < NR; i++) begin
            req_a[i*NB +: NB] = a_v[i];
            req_b[i*NB +: NB] = b_v[i];
        end
        kill_ov = 1'b1;
        req = 4'b0010;
        repeat (6) @(negedge clk);
        chk("mid_run_en", 32'(mul_en), 1);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_mul_rst", 32'(mul_rst), 1);
        chk("abort_mul_en", 32'(mul_en), 0);
        chk("abort_ack", 32'(ack), 0);
        chk("abort_valid", 32'(res_valid), 0);
        chk("abort_mul_a", 32'(mul_a), 0);
        chk("abort_z", 32'(res_z), 0);
        rst = 1'b0;
        kill_ov = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        at_done = 1'b0;
        a_v[2] = 6'd11;
        b_v[2] = 6'd13;
        do_op(4'b0100, 1'b0, 1'b0, gid);
        chk("post_rst_id", gid, 2);
        idle(1);

        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < NR; i++) begin
                a_v[i] = NB'($urandom_range(0, 63));
                b_v[i] = NB'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
            do_op(NR'($urandom_range(1, 15)), 1'b0, 1'b0, gid);
        end
        idle(4);
        chk("queue_empty", q.size(), 0);
        chk("ack_per_grant", n_res, n_iss);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsc_mul_sched.md
DSC_MUL_SCHED -- requirements
Module: dsc_mul_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one dsc_mul instance.
REQ-002 Parameter NUM_BITS, default 6: operand width per input.
REQ-003 Parameter TIMEOUT, default 8192: maximum RUN cycles before abort.
REQ-004 Derived widths: ID_W = clog2(NUM_REQ); CYC_W = clog2(TIMEOUT+1).
REQ-005 clk  in  1: single clock; all logic on rising edge.
REQ-006 rst  in  1: reset, synchronous, active-high.
REQ-007 req  in  NUM_REQ: per-requester request level.
REQ-008 req_a  in  NUM_REQ*NUM_BITS: packed operand a; slice k belongs to requester k.
REQ-009 req_b  in  NUM_REQ*NUM_BITS: packed operand b; slice k belongs to requester k.
REQ-010 ack  out  NUM_REQ: one-hot, one-cycle completion pulse to the served requester.
REQ-011 res_valid  out  1: one-cycle result strobe.
REQ-012 res_id  out  ID_W: index of the served requester.
REQ-013 res_z  out  2*NUM_BITS: product.
REQ-014 res_cycles  out  CYC_W: RUN-state cycle count of the operation.
REQ-015 res_err  out  1: timeout flag, qualified by res_valid.
REQ-016 busy  out  1: high in any state other than IDLE.
REQ-017 mul_rst, mul_en  out  1 each: drive dsc_mul rst/en.
REQ-018 mul_a, mul_b  out  NUM_BITS each: drive dsc_mul a/b.
REQ-019 mul_z  in  2*NUM_BITS; mul_ov  in  1: from dsc_mul z/ov.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, RUN, DONE.
REQ-021 IDLE: when any req bit is high, grant by round-robin starting at pointer ptr, latch that requester's a/b slices and id, and go to LOAD next cycle; with no req, stay in IDLE.
REQ-022 After each grant to k, ptr SHALL become (k+1) mod NUM_REQ; requests are not latched, so a req dropped before grant is ignored.
REQ-023 LOAD (1 cycle): mul_rst=1, mul_en=0, operands stable; if latched a==0 or b==0, go to DONE with res_z=0 and res_cycles=0 (fast path); else go to RUN.
REQ-024 RUN: mul_rst=0, mul_en=1, cycle counter increments each cycle starting from 1 in the first RUN cycle.
REQ-025 RUN, on mul_ov=1: register mul_z into res_z and the count into res_cycles, then go to DONE.
REQ-026 RUN, when count reaches TIMEOUT without mul_ov: go to DONE with res_err=1, res_z=0, res_cycles=TIMEOUT.
REQ-027 DONE (1 cycle): res_valid=1, ack[id]=1, mul_en=0, mul_rst=1; go to IDLE next cycle.
REQ-028 mul_rst SHALL be 1 in every state except RUN; mul_en SHALL be 1 only in RUN.
REQ-029 mul_a/mul_b SHALL hold the latched operands from LOAD through DONE, and 0 in IDLE.
REQ-030 res_z/res_id/res_cycles/res_err hold their value until the next DONE; they are only meaningful with res_valid.
REQ-031 Latency grant-to-res_valid: 2 cycles (fast path), otherwise 2 + RUN cycles.
REQ-032 A requester's req falling after grant does not abort; the result is still delivered with ack.
REQ-033 The requester receiving ack is never granted in the same cycle; back-to-back service resumes in the IDLE cycle following DONE.

Reset
REQ-034 rst SHALL force IDLE, ptr=0, and all outputs to 0 except mul_rst=1, on the next edge, including mid-RUN; no ack is issued for the aborted operation.

Structure
REQ-035 Package dsc_pkg SHALL hold the state enum type and the defaults for NUM_BITS, NUM_REQ and TIMEOUT.
REQ-036 One sub-module, dsc_rr_arb (combinational round-robin grant from req and ptr), SHALL be instantiated; the FSM and counter stay in dsc_mul_sched.

Verification
REQ-037 Single req[0], a=15, b=15, dsc_mul attached -> ack[0] pulse, res_z=225, res_id=0, res_err=0.
REQ-038 req=4'b1111 held, ptr=0 -> ack order 0,1,2,3,0; each res_z matches its operands.
REQ-039 req[2] with a=0, b=37 -> res_valid 2 cycles after grant, res_z=0, res_cycles=0, mul_en never high.
REQ-040 TIMEOUT=16, mul_ov tied 0 -> res_err=1, res_cycles=16, res_z=0 after 16 RUN cycles.
REQ-041 rst asserted 5 cycles into RUN -> next cycle state IDLE, busy=0, mul_rst=1, no ack; a subsequent request completes normally.
REQ-042 1000 random a/b over random req patterns -> every res_z equals a*b, exactly one ack per grant.
